logicnet_neuron_lut_stream: RTL and testbench
=============================================

Name: logicnet_neuron_lut_stream

Overview:
- Runtime-loadable, pipelined successor to the fixed per-neuron truth-table ROMs in the generated LogicNets layers.
- Holds a 2^IN_BITS x OUT_BITS truth table in registers, loaded over a config port.
- Streams lookups through a 2-stage valid/ready pipeline.
- Sits between layer fan-in wiring and the next layer, so one netlist serves retrained models without regeneration.

Parameters:
IN_BITS, 6, neuron fan-in bits (table address width)
OUT_BITS, 2, neuron output bits (table entry width)
DEPTH, 2**IN_BITS, derived table depth; do not override

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  IN_BITS  table write address
cfg_data  in  OUT_BITS  table write data
cfg_done  in  1  request transition LOAD->RUN
cfg_err  out  1  sticky config error flag
state  out  2  00 EMPTY, 01 LOAD, 10 RUN
in_valid  in  1  input handshake valid
in_ready  out  1  input handshake ready
in_data  in  IN_BITS  neuron input vector
out_valid  out  1  output handshake valid
out_ready  in  1  output handshake ready
out_data  out  OUT_BITS  looked-up neuron output

Behaviour:
- Reset (rst_n=0, async):
  - state=EMPTY; all table entries = 0; written-bitmap = 0.
  - Both pipeline valid bits = 0; out_data = 0; cfg_err = 0; in_ready = 0.
- EMPTY:
  - in_ready=0.
  - cfg_we: write entry, set bitmap bit, go to LOAD.
  - cfg_done: cfg_err<=1, stay EMPTY.
- LOAD:
  - in_ready=0.
  - cfg_we: write table[cfg_addr]<=cfg_data, set bitmap[cfg_addr].
  - Rewrites of the same address allowed; last write wins.
  - cfg_done with bitmap all-ones: go to RUN next cycle.
  - cfg_done with any bit clear: cfg_err<=1, stay LOAD.
  - cfg_we and cfg_done in the same cycle: the write is applied first, and completeness includes that write.
- RUN:
  - Lookups enabled.
  - cfg_we while the pipeline is empty (both stage valids 0, in_valid ignored that cycle): go to LOAD, clear bitmap, then apply the write.
  - cfg_we while the pipeline is non-empty: write ignored, cfg_err<=1.
  - cfg_done in RUN: no effect.
- cfg_err clears only on reset.
- Pipeline:
  - Stage 1 registers in_data.
  - Stage 2 registers table[stage1_data] into out_data.
  - Each stage loads when its valid=0 or the downstream stage advances.
  - in_ready = (state==RUN) && (!s1_valid || s2_advance); s2_advance = !out_valid || out_ready.
  - Latency: accept at cycle N -> out_valid at N+2 when out_ready is held high.
  - Throughput: 1 result/cycle.
  - Full back-pressure with no loss or duplication; out_data is stable while out_valid && !out_ready.
- Table is read by stage 2 only. No writes can occur in RUN with in-flight data, so there is no read/write hazard.
- Reset mid-load or mid-stream discards everything and returns to EMPTY with a zero table.

Optional Feature:
LOGICNET_CFG_READBACK_EN
- Defined:
  - Adds ports cfg_rd_en (in, 1), cfg_rd_addr (in, IN_BITS), cfg_rd_data (out, OUT_BITS), cfg_rd_valid (out, 1).
  - Read is registered: cfg_rd_data = table[cfg_rd_addr] and cfg_rd_valid=1 one cycle after cfg_rd_en, in any state.
  - Same-cycle write to the same address returns the old value.
  - Reset values: cfg_rd_data=0, cfg_rd_valid=0.
- Undefined: these ports do not exist; no read logic.

Test Plan:
- Reset, then in_valid=1 -> in_ready=0, state=00, out_valid never rises.
- Load table[a]=2'b11 when a[2]=1 else 2'b00 (all 64 entries), then cfg_done -> state=10.
  - Stream in_data 0..63 with out_ready=1 -> outputs in order, each 2 cycles after accept.
  - in 6'b000100 -> 2'b11; in 6'b111011 -> 2'b00.
- Load 63 of 64 entries, cfg_done -> cfg_err=1, state stays 01.
  - Write the last entry, cfg_done -> state=10; cfg_err remains 1.
- In RUN, stream 8 inputs while toggling out_ready 1/0 every cycle -> exactly 8 outputs in order, out_data held stable during stalls, in_ready drops when both stages are full.
- In RUN, cfg_we while out_valid=1 -> write ignored, cfg_err=1.
  - Drain, then cfg_we addr=5 data=2'b01 -> state=01, in_ready=0.
- Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, state=00, table zero.
  - With LOGICNET_CFG_READBACK_EN: readback of addr 5 gives 2'b00.

Source files
------------

// File: rtl/logicnet_neuron_lut_stream.sv
// logicnet_neuron_lut_stream
//   Runtime-loadable LogicNets neuron: a 2^IN_BITS x OUT_BITS truth table held
//   in registers, filled over a config port, then used for lookups through a
//   2-stage valid/ready pipeline.
//
//   Optional feature macro: LOGICNET_CFG_READBACK_EN adds a registered table
//   readback port (cfg_rd_en/cfg_rd_addr -> cfg_rd_data/cfg_rd_valid).
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   cfg_we/addr/data     table write strobe, address, entry
//   cfg_done             request LOAD -> RUN (needs every entry written)
//   cfg_err              sticky config error, cleared by reset only
//   state                00 EMPTY, 01 LOAD, 10 RUN
//   in_valid/ready/data  lookup request handshake
//   out_valid/ready/data lookup result handshake
module logicnet_neuron_lut_stream #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2,
  parameter int DEPTH    = 2**IN_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [IN_BITS-1:0]  cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_done,
  output logic                cfg_err,
  output logic [1:0]          state,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
`ifdef LOGICNET_CFG_READBACK_EN
  ,
  input  logic                cfg_rd_en,
  input  logic [IN_BITS-1:0]  cfg_rd_addr,
  output logic [OUT_BITS-1:0] cfg_rd_data,
  output logic                cfg_rd_valid
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

  state_e                     state_q, state_d;
  logic [DEPTH-1:0][OUT_BITS-1:0] tbl_q;
  logic [DEPTH-1:0]           wr_map_q, wr_map_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       tbl_we;

  // vld_pipe_q[1] = stage 1 (input register), vld_pipe_q[2] = stage 2 (output)
  logic [2:1]                 vld_pipe_q;
  logic [IN_BITS-1:0]         s1_data_q;
  logic [OUT_BITS-1:0]        out_data_q;

  logic pipe_empty, s1_adv, s2_adv, run_reload, accept;

  assign pipe_empty = (vld_pipe_q == 2'b00);
  assign s2_adv     = !vld_pipe_q[2] || out_ready;
  assign s1_adv     = !vld_pipe_q[1] || s2_adv;
  // A write in RUN with an empty pipe flips us back to LOAD; block the input
  // that cycle so nothing enters the pipe against a table being rewritten.
  assign run_reload = (state_q == ST_RUN) && cfg_we && pipe_empty;
  assign in_ready   = (state_q == ST_RUN) && s1_adv && !run_reload;
  assign accept     = in_valid && in_ready;

  assign state     = state_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = vld_pipe_q[2];
  assign out_data  = out_data_q;

  // Config FSM next state. wr_map_d already includes a same-cycle write, so
  // cfg_done sees the completeness after that write.
  always_comb begin
    state_d   = state_q;
    wr_map_d  = wr_map_q;
    cfg_err_d = cfg_err_q;
    tbl_we    = 1'b0;
    case (state_q)
      ST_EMPTY, ST_LOAD: begin
        if (cfg_we) begin
          tbl_we             = 1'b1;
          wr_map_d[cfg_addr] = 1'b1;
          state_d            = ST_LOAD;
        end
        if (cfg_done) begin
          if (&wr_map_d) state_d   = ST_RUN;
          else           cfg_err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cfg_we) begin
          if (pipe_empty) begin
            tbl_we             = 1'b1;
            wr_map_d           = '0;
            wr_map_d[cfg_addr] = 1'b1;
            state_d            = ST_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      wr_map_q  <= '0;
      cfg_err_q <= 1'b0;
      tbl_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_map_q  <= wr_map_d;
      cfg_err_q <= cfg_err_d;
      if (tbl_we) tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // Lookup pipeline. Data registers only load with valid data so out_data
  // holds its value under back-pressure and between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_data_q  <= '0;
      out_data_q <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe_q[1] <= accept;
        if (accept) s1_data_q <= in_data;
      end
      if (s2_adv) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) out_data_q <= tbl_q[s1_data_q];
      end
    end
  end

`ifdef LOGICNET_CFG_READBACK_EN
  // Registered readback; a same-cycle write lands after the read samples
  // tbl_q, so the old entry is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rd_data  <= '0;
      cfg_rd_valid <= 1'b0;
    end else begin
      cfg_rd_valid <= cfg_rd_en;
      if (cfg_rd_en) cfg_rd_data <= tbl_q[cfg_rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_logicnet_neuron_lut_stream.sv
// Self-checking bench for logicnet_neuron_lut_stream: directed sequence with
// randomized table contents and inputs, checked against a queue-based model.
module tb_logicnet_neuron_lut_stream;
  localparam int IB = 6;
  localparam int OB = 2;
  localparam int D  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IB-1:0] cfg_addr = '0;
  logic [OB-1:0] cfg_data = '0;
  logic          cfg_done = 1'b0;
  logic          cfg_err;
  logic [1:0]    state;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IB-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OB-1:0] out_data;
`ifdef LOGICNET_CFG_READBACK_EN
  logic          cfg_rd_en = 1'b0;
  logic [IB-1:0] cfg_rd_addr = '0;
  logic [OB-1:0] cfg_rd_data;
  logic          cfg_rd_valid;
`endif

  logicnet_neuron_lut_stream #(.IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .state(state),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef LOGICNET_CFG_READBACK_EN
    , .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_data(cfg_rd_data), .cfg_rd_valid(cfg_rd_valid)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int nout  = 0;

  // Reference model: table contents, written set, state, error flag and the
  // ordered list of results owed by the pipe (accepted, not yet delivered).
  logic [OB-1:0] rtbl [D];
  bit            rwr  [D];
  logic [1:0]    rs;
  bit            rerr;
  typedef struct { logic [OB-1:0] d; int c; } exp_t;
  exp_t          q[$];

  bit            lat_chk, tog, last_acc, hold_pend, saw_stall;
  logic [OB-1:0] hold_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_wr();
    foreach (rwr[i]) if (!rwr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    foreach (rtbl[i]) begin rtbl[i] = '0; rwr[i] = 1'b0; end
    rs = 2'b00; rerr = 1'b0; q.delete(); hold_pend = 1'b0;
  endtask

  // One clock: sample at negedge (inputs stable), check, advance model,
  // then return 1 time unit after the posedge.
  task automatic cyc();
    logic [1:0] ps;
    bit acc;
    int qn;
    @(negedge clk);
    ncyc++;
    qn = q.size();
    chk("state", state, rs);
    chk("cfg_err", cfg_err, rerr);
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_val);
    end
    hold_pend = out_valid && !out_ready;
    hold_val  = out_data;
    if (rs != 2'b10 || (cfg_we && qn == 0)) chk("in_ready_gate", in_ready, 0);
    if (rs == 2'b10 && in_valid && !in_ready) saw_stall = 1'b1;
    acc = rst_n && in_valid && in_ready;
    last_acc = acc;
    if (out_valid) chk("out_expected", (qn != 0), 1);
    if (out_valid && out_ready && qn != 0) begin
      exp_t e;
      e = q.pop_front();
      nout++;
      chk("out_data", out_data, e.d);
      if (lat_chk) chk("latency", ncyc - e.c, 2);
    end
    if (acc) q.push_back('{rtbl[in_data], ncyc});
    if (rst_n) begin
      ps = rs;
      if (cfg_we) begin
        if (ps == 2'b10) begin
          if (qn == 0) begin
            foreach (rwr[i]) rwr[i] = 1'b0;
            rtbl[cfg_addr] = cfg_data; rwr[cfg_addr] = 1'b1; rs = 2'b01;
          end else rerr = 1'b1;
        end else begin
          rtbl[cfg_addr] = cfg_data; rwr[cfg_addr] = 1'b1; rs = 2'b01;
        end
      end
      if (cfg_done && ps != 2'b10) begin
        if (all_wr()) rs = 2'b10;
        else          rerr = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (tog) out_ready = ~out_ready;
  endtask

  task automatic wr(input logic [IB-1:0] a, input logic [OB-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic done();
    cfg_done = 1'b1;
    cyc();
    cfg_done = 1'b0;
  endtask

  task automatic send(input logic [IB-1:0] d);
    in_valid = 1'b1; in_data = d;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (last_acc) break;
    end
    chk("send_accept", last_acc, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) cyc();
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int perm[D];
    int miss, x;
    logic [IB-1:0] r;
    model_reset();
    #1;
    chk("rst_state", state, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_iready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Inputs offered while EMPTY are never taken.
    in_valid = 1'b1; in_data = 6'd4;
    repeat (4) begin
      cyc();
      chk("empty_ovalid", out_valid, 0);
    end
    in_valid = 1'b0;

    // Load a[2] ? 11 : 00, in shuffled order after some junk writes.
    for (int i = 0; i < D; i++) perm[i] = i;
    for (int i = D - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 8; i++) wr(IB'($urandom), OB'($urandom));
    for (int i = 0; i < D; i++) wr(IB'(perm[i]), (perm[i] & 4) != 0 ? 2'b11 : 2'b00);
    done();
    cyc();
    chk("run_after_load", state, 2'b10);

    // Full-rate stream 0..63 with fixed 2-cycle latency.
    out_ready = 1'b1; lat_chk = 1'b1;
    for (int i = 0; i < D; i++) send(IB'(i));
    in_valid = 1'b0;
    drain();
    lat_chk = 1'b0;

    // Reload with random data, leaving one address out.
    miss = $urandom_range(D - 1, 0);
    for (int i = 0; i < D; i++) if (i != miss) wr(IB'(i), OB'($urandom));
    done();
    cyc();
    chk("incomplete_state", state, 2'b01);
    chk("incomplete_err", cfg_err, 1);
    wr(IB'(miss), OB'($urandom));
    done();
    cyc();
    chk("complete_state", state, 2'b10);
    chk("err_sticky", cfg_err, 1);

    // Back-pressure: out_ready toggles each cycle.
    tog = 1'b1; saw_stall = 1'b0; nout = 0;
    for (int i = 0; i < 8; i++) send(IB'($urandom));
    in_valid = 1'b0;
    drain();
    tog = 1'b0; out_ready = 1'b1;
    chk("bp_count", nout, 8);
    chk("bp_stall_seen", saw_stall, 1);

    // Write with data in flight is dropped.
    out_ready = 1'b0;
    send(IB'($urandom));
    send(IB'($urandom));
    in_valid = 1'b0;
    chk("inflight_ovalid", out_valid, 1);
    x = $urandom_range(D - 1, 0);
    wr(IB'(x), ~rtbl[x]);
    chk("ignored_state", state, 2'b10);
    out_ready = 1'b1;
    drain();
    send(IB'(x));
    in_valid = 1'b0;
    drain();

    // Write with empty pipe drops back to LOAD.
    wr(IB'(5), 2'b01);
    chk("reload_state", state, 2'b01);
    chk("reload_iready", in_ready, 0);
`ifdef LOGICNET_CFG_READBACK_EN
    cfg_rd_en = 1'b1; cfg_rd_addr = IB'(5);
    cyc();
    cfg_rd_en = 1'b0;
    chk("rd_valid", cfg_rd_valid, 1);
    chk("rd_data", cfg_rd_data, rtbl[5]);
`endif
    for (int i = 0; i < D; i++) if (i != 5) wr(IB'(i), OB'($urandom));
    done();
    cyc();
    chk("run_again", state, 2'b10);

    // Reset mid-stream.
    out_ready = 1'b0;
    r = IB'($urandom);
    send(r);
    in_valid = 1'b0;
    cyc();
    chk("pre_rst_ovalid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", out_valid, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_odata", out_data, 0);
    chk("mid_rst_err", cfg_err, 0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
`ifdef LOGICNET_CFG_READBACK_EN
    cfg_rd_en = 1'b1; cfg_rd_addr = IB'(5);
    cyc();
    cfg_rd_en = 1'b0;
    chk("rst_rd_valid", cfg_rd_valid, 1);
    chk("rst_rd_data", cfg_rd_data, rtbl[5]);
`endif
    chk("final_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
